// File: rtl/tlul_host_tempsensor_poller_pkg.sv
// TL-UL channel structs, opcodes and FSM/step encodings shared by the temperature-sensor poller.
package tlul_host_tempsensor_poller_pkg;

  localparam logic [2:0] OP_PUT_FULL_DATA   = 3'h0;
  localparam logic [2:0] OP_GET             = 3'h4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'h0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP, ST_FIN
  } poller_state_e;

  typedef enum logic [2:0] {
    STEP_CLR, STEP_RST, STEP_CONV, STEP_START, STEP_POLL, STEP_READ, STEP_STOP
  } poller_step_e;

endpackage

// File: rtl/tlul_host_tempsensor_poller.sv
// TL-UL host that runs one temperature-sensor conversion: reset, configure, start, poll DONE,
// read the result and stop the sensor, with one transaction outstanding at a time.
module tlul_host_tempsensor_poller
  import tlul_host_tempsensor_poller_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int unsigned SourceId = 0,
  parameter int unsigned PollGap  = 16,
  parameter int unsigned MaxPolls = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  conv_time_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [23:0] dout_o,
  output logic        err_o,
  output logic        timeout_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  // Handshake: a request is presented with a_valid and held, fields frozen, until a_valid & a_ready;
  // a response is taken only on d_valid & d_ready, and d_ready is high only in ST_WAIT.
  localparam logic [7:0]  SrcId     = 8'(SourceId);
  localparam logic [15:0] MaxPollsW = 16'(MaxPolls);
  localparam logic [7:0]  GapLast   = 8'(PollGap - 1);

  poller_state_e state_q, state_d;
  poller_step_e  step_q, step_d;
  logic [3:0]    conv_q;
  logic [15:0]   poll_cnt_q;
  logic [7:0]    gap_cnt_q;
  logic          to_pend_q;
  logic          err_q;
  logic          timeout_q;
  logic [23:0]   dout_q;

  logic          is_get;
  logic [7:0]    offset;
  logic [31:0]   wdata;
  logic          start_acc;
  logic          rsp_fire;
  logic          rsp_bad;
  logic          poll_done;
  logic          poll_last;
  logic          unused_d;

  assign is_get    = (step_q == STEP_POLL) || (step_q == STEP_READ);
  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign rsp_fire  = (state_q == ST_WAIT) && tl_i.d_valid;
  assign rsp_bad   = tl_i.d_error || (tl_i.d_source != SrcId) ||
                     (tl_i.d_opcode != (is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK));
  assign poll_done = tl_i.d_data[0];
  assign poll_last = (poll_cnt_q + 16'd1) >= MaxPollsW;
  assign unused_d  = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_data[31:24]};

  always_comb begin
    offset = 8'h00;
    wdata  = 32'h0;
    case (step_q)
      STEP_CLR:   begin offset = 8'h04; wdata = 32'h0; end
      STEP_RST:   begin offset = 8'h04; wdata = 32'h1; end
      STEP_CONV:  begin offset = 8'h08; wdata = {28'h0, conv_q}; end
      STEP_START: begin offset = 8'h0C; wdata = 32'h1; end
      STEP_POLL:  offset = 8'h18;
      STEP_READ:  offset = 8'h14;
      STEP_STOP:  begin offset = 8'h0C; wdata = 32'h0; end
      default:    offset = 8'h00;
    endcase
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == ST_ISSUE);
    tl_o.a_opcode  = is_get ? OP_GET : OP_PUT_FULL_DATA;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SrcId;
    tl_o.a_address = BaseAddr + {24'h0, offset};
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = wdata;
    tl_o.d_ready   = (state_q == ST_WAIT);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          step_d  = STEP_CLR;
        end
      end
      ST_ISSUE: begin
        if (tl_i.a_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_fire) begin
          if (rsp_bad) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
            case (step_q)
              STEP_CLR:   step_d = STEP_RST;
              STEP_RST:   step_d = STEP_CONV;
              STEP_CONV:  step_d = STEP_START;
              STEP_START: step_d = STEP_POLL;
              STEP_POLL: begin
                if (poll_done)      step_d  = STEP_READ;
                else if (poll_last) step_d  = STEP_STOP;
                else                state_d = ST_GAP;
              end
              STEP_READ:  step_d  = STEP_STOP;
              default:    state_d = ST_FIN;
            endcase
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = ST_ISSUE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_CLR;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_q     <= 4'h0;
      poll_cnt_q <= 16'h0;
      gap_cnt_q  <= 8'h0;
      to_pend_q  <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      dout_q     <= 24'h0;
    end else begin
      if (start_acc) begin
        conv_q    <= conv_time_i;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
        to_pend_q <= 1'b0;
      end
      if (state_q == ST_GAP && gap_cnt_q != 8'd0) gap_cnt_q <= gap_cnt_q - 8'd1;
      if (rsp_fire) begin
        if (rsp_bad) begin
          err_q <= 1'b1;
        end else begin
          case (step_q)
            STEP_START: poll_cnt_q <= 16'h0;
            STEP_POLL: begin
              poll_cnt_q <= poll_cnt_q + 16'd1;
              gap_cnt_q  <= GapLast;
              if (!poll_done && poll_last) to_pend_q <= 1'b1;
            end
            STEP_READ: dout_q    <= tl_i.d_data[23:0];
            // Timeout is only reported once the sensor has been stopped cleanly.
            STEP_STOP: timeout_q <= to_pend_q;
            default: ;
          endcase
        end
      end
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_FIN);
  assign dout_o    = dout_q;
  assign err_o     = err_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_tlul_host_tempsensor_poller.sv
// Bench for the temperature-sensor poller: device responder plus a transaction-list reference model.
module tb_tlul_host_tempsensor_poller;
  import tlul_host_tempsensor_poller_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam int SRC  = 5;
  localparam int GAP  = 3;
  localparam int MAXP = 4;
  localparam int TW   = 84;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  conv_time_i;
  logic        busy_o, done_o, err_o, timeout_o;
  logic [23:0] dout_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  always #5 clk_i = ~clk_i;

  tlul_host_tempsensor_poller #(
    .BaseAddr(BASE), .SourceId(SRC), .PollGap(GAP), .MaxPolls(MAXP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .conv_time_i(conv_time_i),
    .busy_o(busy_o), .done_o(done_o), .dout_o(dout_o), .err_o(err_o),
    .timeout_o(timeout_o), .tl_o(tl_o), .tl_i(tl_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] got_q[$];
  int exp_lat_q[$];
  int got_lat_q[$];
  logic [23:0] prev_dout;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] txn(input logic [2:0] op, input logic [7:0] off,
                                        input logic [31:0] data);
    logic [31:0] addr;
    addr = BASE + {24'h0, off};
    return {op, 3'd0, 2'd2, 4'hF, 8'(SRC), addr, data};
  endfunction

  function automatic logic [TW-1:0] pack_a(input tl_h2d_t a);
    return {a.a_opcode, a.a_param, a.a_size, a.a_mask, a.a_source, a.a_address, a.a_data};
  endfunction

  // Reference: the bus transaction list a run must produce, the spacing before each request,
  // and the final flags, derived from the sensor's DONE poll number and an injected error index.
  task automatic build_expect(input logic [3:0] ct, input int done_poll, input int err_idx,
                              output logic exp_err, output logic exp_to, output logic exp_read);
    int npolls;
    int s6_idx;
    logic done_in_time;
    exp_q.delete();
    exp_lat_q.delete();
    done_in_time = (done_poll >= 1 && done_poll <= MAXP);
    npolls = done_in_time ? done_poll : MAXP;
    exp_q.push_back(txn(OP_PUT_FULL_DATA, 8'h04, 32'h0));
    exp_q.push_back(txn(OP_PUT_FULL_DATA, 8'h04, 32'h1));
    exp_q.push_back(txn(OP_PUT_FULL_DATA, 8'h08, {28'h0, ct}));
    exp_q.push_back(txn(OP_PUT_FULL_DATA, 8'h0C, 32'h1));
    repeat (4) exp_lat_q.push_back(0);
    for (int k = 1; k <= npolls; k++) begin
      exp_q.push_back(txn(OP_GET, 8'h18, 32'h0));
      exp_lat_q.push_back(k == 1 ? 0 : GAP);
    end
    s6_idx = exp_q.size();
    if (done_in_time) begin
      exp_q.push_back(txn(OP_GET, 8'h14, 32'h0));
      exp_lat_q.push_back(0);
    end
    exp_q.push_back(txn(OP_PUT_FULL_DATA, 8'h0C, 32'h0));
    exp_lat_q.push_back(0);
    exp_to   = !done_in_time;
    exp_err  = 1'b0;
    exp_read = done_in_time;
    if (err_idx >= 0 && err_idx < exp_q.size()) begin
      while (exp_q.size() > err_idx + 1) begin
        void'(exp_q.pop_back());
        void'(exp_lat_q.pop_back());
      end
      exp_err = 1'b1;
      exp_to  = 1'b0;
      if (err_idx <= s6_idx) exp_read = 1'b0;
    end
  endtask

  task automatic run_one(input logic [3:0] ct, input int done_poll, input logic [23:0] dval,
                         input int err_idx, input int err_kind, input bit rnd,
                         input bit stall_s3, input bit busy_start, input int reset_poll);
    logic exp_err, exp_to, exp_read;
    int cyc, resp_edge, stall, rsp_wait, n_rsp, polls_req, polls_rsp, stable_bad, extra_av;
    bit in_a, pend_rsp, seen_done, aborted;
    logic [TW-1:0] first;
    logic [7:0] last_off;
    logic last_get;
    logic [31:0] rdata;

    build_expect(ct, done_poll, err_idx, exp_err, exp_to, exp_read);
    got_q.delete();
    got_lat_q.delete();
    cyc = 0; resp_edge = 1; stall = 0; rsp_wait = 0; n_rsp = 0; polls_req = 0; polls_rsp = 0;
    stable_bad = 0; in_a = 0; pend_rsp = 0; seen_done = 0; aborted = 0;
    first = '0; last_off = 8'h0; last_get = 1'b0;

    @(negedge clk_i);
    start_i = 1'b1;
    conv_time_i = ct;
    while (cyc < 600 && !seen_done && !aborted) begin
      @(negedge clk_i);
      cyc++;
      start_i = (busy_start && cyc == 3);
      conv_time_i = 4'($urandom);
      tl_i.d_valid = 1'b0;
      if (cyc == 1) begin
        check("start_busy", busy_o, 1'b1);
        check("start_err_clr", err_o, 1'b0);
        check("start_to_clr", timeout_o, 1'b0);
      end
      if (done_o) begin
        seen_done = 1;
        check("done_lat", cyc - resp_edge, 0);
        check("done_busy", busy_o, 1'b1);
      end else begin
        if (tl_o.a_valid) begin
          if (!in_a) begin
            in_a = 1;
            first = pack_a(tl_o);
            got_lat_q.push_back(cyc - resp_edge);
            stall = rnd ? int'($urandom_range(0, 3)) : 0;
            if (stall_s3 && tl_o.a_address == BASE + 32'h8) stall = 5;
          end else if (pack_a(tl_o) !== first) begin
            stable_bad++;
          end
          if (stall == 0) begin
            tl_i.a_ready = 1'b1;
            got_q.push_back(first);
            in_a = 0;
            pend_rsp = 1;
            rsp_wait = rnd ? int'($urandom_range(0, 2)) : 0;
            last_off = 8'(tl_o.a_address - BASE);
            last_get = (tl_o.a_opcode == OP_GET);
            if (last_off == 8'h18) polls_req++;
          end else begin
            tl_i.a_ready = 1'b0;
            stall--;
          end
        end else begin
          tl_i.a_ready = 1'b0;
        end

        if (tl_o.d_ready && pend_rsp && reset_poll > 0 && last_off == 8'h18 &&
            polls_req == reset_poll) begin
          rst_i = 1'b1;
          tl_i = '0;
          #1;
          check("rst_a_valid", tl_o.a_valid, 1'b0);
          check("rst_d_ready", tl_o.d_ready, 1'b0);
          check("rst_busy", busy_o, 1'b0);
          check("rst_dout", dout_o, 24'h0);
          @(negedge clk_i);
          check("rst_hold_a_valid", tl_o.a_valid, 1'b0);
          rst_i = 1'b0;
          prev_dout = 24'h0;
          extra_av = 0;
          repeat (5) begin
            @(negedge clk_i);
            if (tl_o.a_valid || busy_o) extra_av++;
          end
          check("rst_no_stale", extra_av, 0);
          check("rst_flags", {err_o, timeout_o, done_o}, 3'b000);
          aborted = 1;
        end else if (tl_o.d_ready && pend_rsp) begin
          if (rsp_wait > 0) begin
            rsp_wait--;
          end else begin
            rdata = $urandom;
            if (last_off == 8'h18) begin
              polls_rsp++;
              rdata[0] = (done_poll != 0 && polls_rsp >= done_poll);
            end else if (last_off == 8'h14) begin
              rdata[23:0] = dval;
            end
            tl_i.d_valid  = 1'b1;
            tl_i.d_opcode = last_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
            tl_i.d_source = 8'(SRC);
            tl_i.d_size   = 2'd2;
            tl_i.d_error  = 1'b0;
            tl_i.d_data   = rdata;
            if (n_rsp == err_idx) begin
              case (err_kind)
                0:       tl_i.d_error = 1'b1;
                1:       tl_i.d_source = 8'(SRC + 1);
                default: tl_i.d_opcode = last_get ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA;
              endcase
            end
            pend_rsp = 0;
            n_rsp++;
            resp_edge = cyc + 1;
          end
        end else if (!tl_o.d_ready && rnd && $urandom_range(0, 4) == 0) begin
          tl_i.d_valid  = 1'b1;
          tl_i.d_opcode = OP_ACCESS_ACK_DATA;
          tl_i.d_source = 8'(SRC);
          tl_i.d_error  = 1'b1;
          tl_i.d_data   = $urandom | 32'h1;
        end
      end
    end
    tl_i = '0;
    if (aborted) return;
    if (!seen_done) check("done_seen", 1'b0, 1'b1);

    check("n_txn", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("txn%0d", i), got_q[i], exp_q[i]);
    for (int i = 0; i < got_lat_q.size() && i < exp_lat_q.size(); i++)
      check($sformatf("lat%0d", i), got_lat_q[i], exp_lat_q[i]);
    check("a_stable", stable_bad, 0);
    if (exp_read) prev_dout = dval;
    check("err", err_o, exp_err);
    check("timeout", timeout_o, exp_to);
    check("dout", dout_o, prev_dout);
    @(negedge clk_i);
    check("done_pulse", {done_o, busy_o}, 2'b00);
    extra_av = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (tl_o.a_valid || busy_o) extra_av++;
    end
    check("no_extra_run", extra_av, 0);
    check("flags_hold", {err_o, timeout_o}, {exp_err, exp_to});
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    conv_time_i = 4'h0;
    tl_i = '0;
    prev_dout = 24'h0;
    repeat (3) @(negedge clk_i);
    check("reset_outs", {busy_o, done_o, err_o, timeout_o}, 4'b0000);
    check("reset_dout", dout_o, 24'h0);
    check("reset_tl", {tl_o.a_valid, tl_o.d_ready}, 2'b00);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    run_one(4'h5, 3, 24'hABCDEF, -1, 0, 0, 0, 0, 0);
    run_one(4'hA, 1, 24'h123456, -1, 0, 0, 1, 0, 0);
    run_one(4'h3, 2, 24'h777777,  3, 0, 0, 0, 0, 0);
    run_one(4'h7, 0, 24'h000001, -1, 0, 0, 0, 0, 0);
    run_one(4'h6, 0, 24'h000002,  8, 2, 0, 0, 0, 0);
    run_one(4'h2, 2, 24'h0F0F0F, -1, 0, 1, 0, 1, 0);
    run_one(4'h9, 0, 24'h5A5A5A, -1, 0, 1, 0, 0, 2);
    run_one(4'h4, 1, 24'hC0FFEE, -1, 0, 1, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      run_one(4'($urandom), int'($urandom_range(0, MAXP + 1)), 24'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
              int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlul_host_tempsensor_poller.md
TLUL_HOST_TEMPSENSOR_POLLER -- requirements
Module: tlul_host_tempsensor_poller

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h0, meaning byte base address of the temperature-sensor register window.
REQ-002 SHALL have parameter SourceId, default 0, meaning the value driven on a_source.
REQ-003 SHALL have parameter PollGap, default 16, meaning idle cycles (1..255) between successive DONE polls.
REQ-004 SHALL have parameter MaxPolls, default 1024, meaning the DONE polls (1..65535) allowed before a timeout.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start_i, input, 1 bit: single-cycle request to run one conversion.
REQ-008 SHALL have port conv_time_i, input, 4 bits: conversion-time select, captured when start_i is accepted.
REQ-009 SHALL have port busy_o, output, 1 bit: high while a sequence is running.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse at sequence end.
REQ-011 SHALL have port dout_o, output, 24 bits: last successful conversion result.
REQ-012 SHALL have port err_o, output, 1 bit: qualifies done_o; set for a bus error.
REQ-013 SHALL have port timeout_o, output, 1 bit: qualifies done_o; set for a poll timeout.
REQ-014 SHALL have port tl_o, output, tl_h2d_t: TL-UL host A channel and d_ready.
REQ-015 SHALL have port tl_i, input, tl_d2h_t: TL-UL device D channel and a_ready.

Function
REQ-016 The block SHALL be a TL-UL initiator with at most one transaction outstanding.
REQ-017 Every request SHALL drive a_size=2, a_mask=4'hF, a_source=SourceId and a_param=0, and SHALL drive every other unlisted field to 0.
REQ-018 Once asserted, a_valid SHALL stay high with all A fields stable until the cycle where a_valid&a_ready is high; it SHALL then deassert the next cycle.
REQ-019 d_ready SHALL be high only while a response is awaited; a response SHALL be accepted on d_valid&d_ready.
REQ-020 Sequence steps, with address BaseAddr+offset, SHALL be:
  - S1: PutFullData 0x04, data 0.
  - S2: PutFullData 0x04, data 1.
  - S3: PutFullData 0x08, data = captured conv_time zero-extended.
  - S4: PutFullData 0x0C, data 1.
  - S5: Get 0x18 (poll), repeated.
  - S6: Get 0x14.
  - S7: PutFullData 0x0C, data 0.
REQ-021 FSM states SHALL be IDLE, ISSUE (a_valid high), WAIT (d_ready high), GAP (poll spacing) and FIN (done_o pulse); a step register SHALL select S1..S7.
REQ-022 start_i high in IDLE at cycle t SHALL make busy_o=1 and a_valid=1 (S1) at cycle t+1; start_i outside IDLE SHALL be ignored.
REQ-023 After a good response at cycle t, the next step's a_valid SHALL rise at t+1, except after a S5 response with d_data[0]=0.
REQ-024 A S5 response with d_data[0]=0 SHALL enter GAP for exactly PollGap cycles, then reissue S5.
REQ-025 A S5 response with d_data[0]=1 SHALL proceed to S6.
REQ-026 The S6 response SHALL load dout_o <= d_data[23:0] on the accept cycle.
REQ-027 The 16-bit poll counter SHALL clear at S4 and increment per S5 response.
REQ-028 If the counter reaches MaxPolls with DONE=0, the block SHALL skip S6, perform S7, and end with timeout_o=1.
REQ-029 A response SHALL be treated as a bus error when any of the following holds:
  - d_error=1;
  - d_source≠SourceId;
  - d_opcode≠AccessAckData for a Get;
  - d_opcode≠AccessAck for a Put.
REQ-030 On a bus error, the block SHALL go straight to FIN with err_o=1, issue no further requests, and leave dout_o unchanged.
REQ-031 The cycle after the final S7 response (or after the error response), FIN SHALL assert done_o=1 for one cycle with busy_o=1, then return to IDLE.
REQ-032 err_o and timeout_o SHALL hold their values until the next accepted start_i clears them; if both conditions occur, err_o SHALL take priority and timeout_o SHALL stay 0.
REQ-033 A D-channel beat arriving while no response is awaited SHALL be ignored.

Reset
REQ-034 While rst_i is high, the block SHALL asynchronously force: state IDLE, a_valid=0, d_ready=0, busy_o=0, done_o=0, err_o=0, timeout_o=0, dout_o=0, poll counter=0.
REQ-035 Reset asserted mid-transaction SHALL abandon that transaction; after release, no stale request SHALL be reissued until start_i.

Verification
REQ-036 start_i with conv_time_i=4'h5, zero-wait responder, DONE=1 on the 3rd poll, DOUT=24'hABCDEF -> the bus carries 0x04:0, 0x04:1, 0x08:5, 0x0C:1, then 3 reads of 0x18 spaced PollGap, then read 0x14, then 0x0C:0; done_o pulses; dout_o=24'hABCDEF; err_o=0.
REQ-037 a_ready held low for 5 cycles on S3 -> a_valid, a_address and a_data stay stable for all 6 cycles; exactly one S3 is accepted.
REQ-038 d_error=1 on the S4 response -> no further A requests; done_o pulses the next cycle with err_o=1; dout_o holds its prior value.
REQ-039 MaxPolls=4 and DONE never set -> exactly 4 polls, then the 0x0C:0 write; done_o pulses with timeout_o=1 and err_o=0.
REQ-040 rst_i pulsed while in WAIT for S5, then start_i re-pulsed -> a_valid=0 during reset; the new run restarts at S1 with cleared flags.
REQ-041 start_i pulsed while busy_o=1 -> the run is unaffected and no second sequence follows.
